// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: instruction register and program counter for the fetch stage.
//   Holds the fetched instruction word (ir) and exposes its 8-bit decode
//   opcode to the control FSM. On PCe the PC steps by +1, by a taken
//   conditional branch/jump, or by jump-and-link. A HALT opcode freezes
//   the PC until resume.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   i_en, instr_in        load instr_in into ir at the next edge
//   PCe                   advance the PC at the next edge per current ir
//   take_branch           condition result for the current ir's cond field
//   rtarget_val           contents of register ir[3:0] (jump target)
//   resume                leave the HALTED state
//   pc, ir                registered program counter / instruction register
//   opcode                {ir[15:12], ir[7:4]}, combinational from ir
//   link_data, link_we    JAL return address and its one-cycle write strobe
//   halted                high while in the HALTED state
module fetch_pc_unit #(
    parameter int unsigned       ADDR_W    = 16,
    parameter int unsigned       DATA_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter logic [7:0]        HALT_OP   = 8'hFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_en,
    input  logic              PCe,
    input  logic [DATA_W-1:0] instr_in,
    input  logic              take_branch,
    input  logic [DATA_W-1:0] rtarget_val,
    input  logic              resume,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic [7:0]        opcode,
    output logic [DATA_W-1:0] link_data,
    output logic              link_we,
    output logic              halted
);

    localparam int unsigned DISP_W = 8;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [DATA_W-1:0]   r_ir;
    logic [DATA_W-1:0]   r_link_data;
    logic                r_link_we;
    logic                r_halted;

    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic [DATA_W-1:0]   w_link_data_nxt;
    logic                w_link_we_nxt;

    logic [7:0]          w_opcode;
    logic [ADDR_W-1:0]   w_disp;
    logic [ADDR_W-1:0]   w_pc_inc;
    logic [ADDR_W-1:0]   w_pc_br;
    logic [ADDR_W-1:0]   w_rtarget;
    logic                w_is_halt;
    logic                w_is_bcond;
    logic                w_is_jcond;
    logic                w_is_jal;

    // Decode of the instruction currently held in ir
    assign w_opcode   = {r_ir[15:12], r_ir[7:4]};
    assign w_is_halt  = (w_opcode == HALT_OP);
    assign w_is_bcond = (r_ir[15:12] == 4'b1100);
    assign w_is_jcond = (r_ir[15:12] == 4'b0100) && (r_ir[7:4] == 4'b1100);
    assign w_is_jal   = (r_ir[15:12] == 4'b0100) && (r_ir[7:4] == 4'b1000);

    // PC candidates; all arithmetic wraps modulo 2^ADDR_W
    assign w_disp    = {{(ADDR_W-DISP_W){r_ir[DISP_W-1]}}, r_ir[DISP_W-1:0]};
    assign w_pc_inc  = r_pc + ADDR_W'(1);
    assign w_pc_br   = r_pc + w_disp;
    assign w_rtarget = rtarget_val[ADDR_W-1:0];

    // State register and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_RUN;
            r_pc        <= RESET_VEC;
            r_ir        <= '0;
            r_link_data <= '0;
            r_link_we   <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_link_data <= w_link_data_nxt;
            r_link_we   <= w_link_we_nxt;
            r_halted    <= (w_state_nxt == ST_HALTED);
            if (i_en) begin
                r_ir <= instr_in;
            end
        end
    end

    // Next-state and PC selection; HALT wins over any other decode class
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_link_data_nxt = r_link_data;
        w_link_we_nxt   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (PCe) begin
                    if (w_is_halt) begin
                        w_state_nxt = ST_HALTED;
                    end else if (w_is_bcond) begin
                        w_pc_nxt = take_branch ? w_pc_br : w_pc_inc;
                    end else if (w_is_jcond) begin
                        w_pc_nxt = take_branch ? w_rtarget : w_pc_inc;
                    end else if (w_is_jal) begin
                        w_pc_nxt        = w_rtarget;
                        w_link_data_nxt = DATA_W'(w_pc_inc);
                        w_link_we_nxt   = 1'b1;
                    end else begin
                        w_pc_nxt = w_pc_inc;
                    end
                end
            end
            ST_HALTED: begin
                // PCe is ignored here; only resume moves the PC on
                if (resume) begin
                    w_state_nxt = ST_RUN;
                    w_pc_nxt    = w_pc_inc;
                end
            end
        endcase
    end

    assign pc        = r_pc;
    assign ir        = r_ir;
    assign opcode    = w_opcode;
    assign link_data = r_link_data;
    assign link_we   = r_link_we;
    assign halted    = r_halted;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: the driver pushes the reference
// model's expected post-edge state; the monitor pops and compares.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        i_en = 1'b0;
    logic        PCe = 1'b0;
    logic [15:0] instr_in = '0;
    logic        take_branch = 1'b0;
    logic [15:0] rtarget_val = '0;
    logic        resume = 1'b0;
    logic [15:0] pc;
    logic [15:0] ir;
    logic [7:0]  opcode;
    logic [15:0] link_data;
    logic        link_we;
    logic        halted;

    fetch_pc_unit #(
        .ADDR_W(16), .DATA_W(16), .RESET_VEC(16'h0000), .HALT_OP(8'hFF)
    ) dut (
        .clk(clk), .reset_n(reset_n), .i_en(i_en), .PCe(PCe),
        .instr_in(instr_in), .take_branch(take_branch),
        .rtarget_val(rtarget_val), .resume(resume),
        .pc(pc), .ir(ir), .opcode(opcode),
        .link_data(link_data), .link_we(link_we), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] ir;
        logic [15:0] link_data;
        logic        link_we;
        logic        halted;
    } exp_t;

    exp_t exp_q[$];
    event mon_ev;
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state
    int          m_pc;
    logic [15:0] m_ir;
    logic [15:0] m_ld;
    bit          m_we;
    bit          m_halt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pc = 0; m_ir = '0; m_ld = '0; m_we = 0; m_halt = 0;
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.pc = 16'(m_pc); e.ir = m_ir; e.link_data = m_ld;
        e.link_we = m_we; e.halted = m_halt;
        exp_q.push_back(e);
    endfunction

    // Architectural rules applied to the pre-edge ir, plain integer PC math
    function automatic void model_step(input bit en, input logic [15:0] instr,
                                       input bit pce, input bit tb,
                                       input logic [15:0] rt, input bit res);
        logic [7:0] op;
        int d;
        op = {m_ir[15:12], m_ir[7:4]};
        d = int'(m_ir[7:0]);
        if (d > 127) d = d - 256;
        m_we = 0;
        if (m_halt) begin
            if (res) begin
                m_halt = 0;
                m_pc = (m_pc + 1) % 65536;
            end
        end else if (pce) begin
            if (op == 8'hFF) m_halt = 1;
            else if (m_ir[15:12] == 4'hC)
                m_pc = tb ? (m_pc + d + 65536) % 65536 : (m_pc + 1) % 65536;
            else if (m_ir[15:12] == 4'h4 && m_ir[7:4] == 4'hC)
                m_pc = tb ? int'(rt) : (m_pc + 1) % 65536;
            else if (m_ir[15:12] == 4'h4 && m_ir[7:4] == 4'h8) begin
                m_ld = 16'((m_pc + 1) % 65536);
                m_pc = int'(rt);
                m_we = 1;
            end else m_pc = (m_pc + 1) % 65536;
        end
        if (en) m_ir = instr;
    endfunction

    task automatic cyc(input bit en, input logic [15:0] instr, input bit pce,
                       input bit tb, input logic [15:0] rt, input bit res);
        @(negedge clk);
        i_en = en; instr_in = instr; PCe = pce;
        take_branch = tb; rtarget_val = rt; resume = res;
        model_step(en, instr, pce, tb, rt, res);
        push_exp();
    endtask

    task automatic load(input logic [15:0] instr);
        cyc(1, instr, 0, 0, 16'h0, 0);
    endtask

    task automatic pce(input bit tb, input logic [15:0] rt);
        cyc(0, 16'h0, 1, tb, rt, 0);
    endtask

    // Move the PC with a taken Jcond
    task automatic set_pc(input logic [15:0] target);
        load(16'h40C0);
        pce(1, target);
    endtask

    // Drop reset between edges and check its effect immediately
    task automatic async_reset();
        @(posedge clk);
        #3;
        i_en = 0; PCe = 0; take_branch = 0; resume = 0;
        reset_n = 1'b0;
        #1;
        model_reset();
        push_exp();
        -> mon_ev;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Sample point: 1 time unit after every rising edge
    always @(posedge clk) begin
        #1;
        -> mon_ev;
    end

    // Monitor: compare DUT outputs against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(mon_ev);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pc", 32'(pc), 32'(e.pc));
                chk("ir", 32'(ir), 32'(e.ir));
                chk("opcode", 32'(opcode), 32'({e.ir[15:12], e.ir[7:4]}));
                chk("link_we", 32'(link_we), 32'(e.link_we));
                chk("link_data", 32'(link_data), 32'(e.link_data));
                chk("halted", 32'(halted), 32'(e.halted));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] instr;
        // Power-on reset
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        push_exp();
        -> mon_ev;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Sequential NOPs: 0 -> 1 -> 2 -> 3
        repeat (3) begin
            load(16'h0000);
            pce(0, 16'h0);
        end

        // Backward branch, taken and not taken
        set_pc(16'h0010);
        load(16'hC0FC);
        pce(1, 16'h0);
        set_pc(16'h0010);
        load(16'hC0FC);
        pce(0, 16'h0);

        // Jcond not taken, then JAL and the cycle after its strobe
        load(16'h40C5);
        pce(0, 16'h1234);
        set_pc(16'h0020);
        load(16'h4385);
        pce(0, 16'h0100);
        cyc(0, 16'h0, 0, 0, 16'h0, 0);

        // Wrap-around of increment and of branch
        set_pc(16'hFFFF);
        load(16'h0000);
        pce(0, 16'h0);
        set_pc(16'h0002);
        load(16'hC0F0);
        pce(1, 16'h0);

        // Simultaneous load and advance: branch decodes the old ir
        cyc(1, 16'h0000, 1, 1, 16'h0, 0);

        // Halt, ignored PCe and a load while halted, then resume with PCe
        load(16'hF0F0);
        pce(0, 16'h0);
        repeat (5) pce(1, 16'h5555);
        cyc(1, 16'h0000, 0, 0, 16'h0, 0);
        cyc(0, 16'h0, 1, 0, 16'h0, 1);
        cyc(0, 16'h0, 0, 0, 16'h0, 1);

        // Async reset while halted
        set_pc(16'h0040);
        load(16'hF0F0);
        pce(0, 16'h0);
        async_reset();

        // Async reset during the link_we pulse
        set_pc(16'h0300);
        load(16'h4A80);
        pce(0, 16'h0777);
        async_reset();

        // Randomized traffic across all decode classes
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0: instr = 16'($urandom);
                1: instr = {4'hC, 4'($urandom_range(0, 15)), 8'($urandom)};
                2: instr = {4'h4, 4'($urandom_range(0, 15)), 4'hC, 4'($urandom_range(0, 15))};
                3: instr = {4'h4, 4'($urandom_range(0, 15)), 4'h8, 4'($urandom_range(0, 15))};
                4: instr = {4'hF, 4'($urandom_range(0, 15)), 4'hF, 4'($urandom_range(0, 15))};
                default: instr = 16'h0000;
            endcase
            cyc(bit'($urandom_range(0, 1)), instr, bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 1)), 16'($urandom),
                ($urandom_range(0, 3) == 0));
        end

        @(negedge clk);
        i_en = 0; PCe = 0; take_branch = 0; resume = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Instruction-fetch and program-counter stage that feeds the processor control FSM. Latches the fetched instruction word into the instruction register on `i_en`. Presents the 8-bit decode opcode `{ir[15:12], ir[7:4]}` to the FSM. Updates the PC on `PCe` by increment, conditional branch, conditional jump, or jump-and-link, and supports a HALT instruction with an external resume.

Parameters:
ADDR_W, 16, PC and instruction-address width
DATA_W, 16, instruction and register data width
RESET_VEC, 0, PC value loaded on reset
HALT_OP, 8'hFF, decode opcode that halts the PC

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
i_en  input  1  load instr_in into IR at next edge
PCe  input  1  advance PC at next edge according to current IR
instr_in  input  DATA_W  instruction word read from memory at address pc
take_branch  input  1  condition result from the flag unit for the current IR's cond field
rtarget_val  input  DATA_W  contents of register ir[3:0] (jump target)
resume  input  1  leave HALTED state
pc  output  ADDR_W  current program counter (instruction fetch address)
ir  output  DATA_W  instruction register
opcode  output  8  {ir[15:12], ir[7:4]}, combinational from ir
link_data  output  DATA_W  return address for JAL, zero-extended
link_we  output  1  one-cycle write strobe for link_data into register ir[11:8]
halted  output  1  high while in HALTED state

Behaviour:
- Reset (reset_n low, asynchronous): pc=RESET_VEC, ir=0 (NOP), link_data=0, link_we=0, state=RUN, halted=0.
- Reset mid-operation (any state, including HALTED): same values as above, effective immediately.
- IR load: i_en high at an edge → ir <= instr_in. opcode reflects the new ir in the same cycle after the edge. With i_en low, ir holds.
- Decode classes (on ir):
  - Bcond: ir[15:12]=4'b1100; disp = sign-extended ir[7:0].
  - Jcond: ir[15:12]=4'b0100 and ir[7:4]=4'b1100.
  - JAL: ir[15:12]=4'b0100 and ir[7:4]=4'b1000.
  - HALT: opcode==HALT_OP.
  - Everything else is sequential.
- PC update in state RUN, with PCe high at an edge:
  - Bcond and take_branch → pc <= pc + disp, modulo 2^ADDR_W.
  - Jcond and take_branch → pc <= rtarget_val[ADDR_W-1:0].
  - JAL (unconditional) → pc <= rtarget_val[ADDR_W-1:0]; link_data <= pc+1; link_we <= 1 for exactly one cycle.
  - HALT → pc unchanged; state <= HALTED.
  - Otherwise → pc <= pc+1.
- Bcond/Jcond with take_branch low: pc <= pc+1.
- Wrap-around: pc+1 at 2^ADDR_W-1 gives 0. Branch arithmetic wraps in both directions.
- link_we is low in every cycle that does not directly follow a JAL PCe edge.
- Simultaneous i_en and PCe at one edge: the PC update decodes the ir value held before the edge; ir loads instr_in at the same edge.
- State HALTED:
  - PCe is ignored; pc holds; halted=1.
  - i_en still loads ir.
  - resume high at an edge → state <= RUN, pc <= pc+1, halted=0 after that edge.
  - resume is ignored in RUN.
  - resume together with PCe in HALTED: only the resume action applies.
- No internal latency beyond one edge. pc and ir are registered outputs; opcode is combinational.

Test Plan:
- Reset then sequence: release reset_n; pulse i_en with instr_in=16'h0000, then PCe, repeated 3 times → pc 0→1→2→3, opcode=8'h00, link_we never high.
- Branch backward: pc=16'h0010, load ir=16'hC0FC (disp -4), take_branch=1, PCe → pc=16'h000C. Repeat with take_branch=0 → pc=16'h0011.
- Jcond/JAL: ir=16'h40C5, rtarget_val=16'h1234, take_branch=0, PCe → pc+1. Then ir=16'h4385, pc=16'h0020, rtarget_val=16'h0100, PCe → pc=16'h0100, link_data=16'h0021, link_we high for exactly 1 cycle.
- Wrap: pc=16'hFFFF with NOP, PCe → pc=16'h0000. Also pc=16'h0002 with Bcond disp 8'hF0 taken → pc=16'hFFF2.
- Halt/resume: ir=16'hF0F0 (opcode 8'hFF), PCe → halted=1, pc held over 5 further PCe pulses. Pulse resume → pc+1, halted=0.
- Async reset in HALTED and during a link_we pulse: drop reset_n between edges → pc=RESET_VEC, ir=0, halted=0, link_we=0 immediately, without waiting for a clock edge.
